row_by_vector_engine: RTL and testbench

Parametrised row-by-vector dot-product engine for the matrix-vector stage of the solver datapath. Accepts a row and the matching vector slice as a stream of NI-lane chunks, multiplies lane-wise, reduces through a pipelined adder tree, and accumulates across a run-time chunk count. Both input and output use valid/ready handshakes, with backpressure. This replaces the fixed 8-lane, pulse-signalled row engine.

---
 rtl/rbv_pkg.sv | 52 +++++
 rtl/row_by_vector_engine_lane_tree.sv | 70 +++++++
 rtl/row_by_vector_engine.sv | 127 ++++++++++++
 tb/tb_row_by_vector_engine.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rbv_pkg.sv
// rbv_pkg
// Shared types and helpers for the row-by-vector dot-product engine.
//   rbv_state_t : controller states (IDLE, RUN, DRAIN, DONE)
//   PIPE_DEPTH  : number of registered stages inside rbv_lane_tree (S1, S2)
//   rbv_narrow  : arithmetic right shift by the fractional bits followed by
//                 narrowing to the element width.
// Configuration macro: ROW_BY_VECTOR_SATURATE_EN
//   defined   -> narrowing clamps to the signed element range
//   undefined -> narrowing keeps the low element bits (two's-complement wrap)
package rbv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rbv_state_t;

  localparam int PIPE_DEPTH = 2;

  // Working width of the narrowing helper; every accumulator is sign-extended
  // to this before shifting so one function serves all parameterisations.
  localparam int NARROW_W = 256;

  // Returns the shifted value with either saturation applied or the bits
  // above elem_width cleared; callers keep the low elem_width bits.
  function automatic logic [NARROW_W-1:0] rbv_narrow(
    input logic signed [NARROW_W-1:0] acc,
    input int                         frac_bits,
    input int                         elem_width
  );
    logic signed [NARROW_W-1:0] shifted;
    logic signed [NARROW_W-1:0] max_val;
    logic signed [NARROW_W-1:0] min_val;
    shifted = acc >>> frac_bits;
    max_val = $signed((NARROW_W'(1) << (elem_width - 1)) - NARROW_W'(1));
    min_val = -max_val - $signed(NARROW_W'(1));
`ifdef ROW_BY_VECTOR_SATURATE_EN
    if (shifted > max_val) begin
      return max_val;
    end else if (shifted < min_val) begin
      return min_val;
    end else begin
      return shifted;
    end
`else
    // Wrap: the element range mask is max_val with its sign bit restored.
    return shifted & (max_val | (-min_val));
`endif
  endfunction

endpackage

// File: rtl/row_by_vector_engine_lane_tree.sv
// rbv_lane_tree
// Lane multipliers plus a two-stage registered reduction.
//   S1: NI signed full-width products are registered.
//   S2: the sum of the registered products is registered.
// Ports:
//   clk, reset       clock and asynchronous active-high reset
//   in_valid         a/p carry a chunk to be multiplied this cycle
//   a, p             NI lanes of ELEMENT_WIDTH, lane k at [k*EW +: EW]
//   s1_valid         S1 holds valid products
//   sum, sum_valid   registered lane sum (S2) and its valid bit
module rbv_lane_tree
  import rbv_pkg::*;
#(
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = 32,
  localparam int PROD_W       = 2 * ELEMENT_WIDTH,
  localparam int SUM_W        = PROD_W + $clog2(NI)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  logic [NI*ELEMENT_WIDTH-1:0]   a,
  input  logic [NI*ELEMENT_WIDTH-1:0]   p,
  output logic                          s1_valid,
  output logic signed [SUM_W-1:0]       sum,
  output logic                          sum_valid
);

  localparam int EW = ELEMENT_WIDTH;

  logic signed [PROD_W-1:0] prod_d [NI];
  logic signed [PROD_W-1:0] prod_q [NI];
  logic signed [SUM_W-1:0]  tree_sum;
  logic [PIPE_DEPTH-1:0]    vld_pipe;

  // Both operands are sign-extended to the product width first, so the low
  // PROD_W bits of the multiply are the exact signed product.
  for (genvar k = 0; k < NI; k++) begin : g_lane
    assign prod_d[k] = PROD_W'($signed(a[k*EW +: EW])) * PROD_W'($signed(p[k*EW +: EW]));
  end

  // Reduction of the S1 products; the extra log2(NI) bits make it exact.
  always_comb begin
    tree_sum = '0;
    for (int k = 0; k < NI; k++) begin
      tree_sum = tree_sum + SUM_W'(prod_q[k]);
    end
  end

  // Valid bits travel alongside the data; data registers only load on valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_pipe <= '0;
      prod_q   <= '{default: '0};
      sum      <= '0;
    end else begin
      vld_pipe <= {vld_pipe[PIPE_DEPTH-2:0], in_valid};
      if (in_valid) begin
        prod_q <= prod_d;
      end
      if (vld_pipe[0]) begin
        sum <= tree_sum;
      end
    end
  end

  assign s1_valid  = vld_pipe[0];
  assign sum_valid = vld_pipe[PIPE_DEPTH-1];

endmodule

// File: rtl/row_by_vector_engine.sv
// row_by_vector_engine
// Streams a row and its vector slice as NI-lane chunks, multiplies lane-wise,
// reduces through rbv_lane_tree, accumulates no_of_multiples chunks (S3) and
// presents the fixed-point dot product on a valid/ready output.
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   start, no_of_multiples     begin a row of the given chunk count (IDLE only)
//   a, p, in_valid, in_ready   chunk input handshake
//   result, result_valid,
//   result_ready               result output handshake
//   busy                       engine is not in IDLE
// Configuration macro: ROW_BY_VECTOR_SATURATE_EN selects saturating narrowing
// of the result; without it the result wraps.
module row_by_vector_engine
  import rbv_pkg::*;
#(
  parameter int NI            = 8,
  parameter int ELEMENT_WIDTH = 32,
  parameter int FRAC_BITS     = 16,
  parameter int ACC_WIDTH     = 2 * ELEMENT_WIDTH + 16,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [CNT_WIDTH-1:0]        no_of_multiples,
  input  logic [NI*ELEMENT_WIDTH-1:0] a,
  input  logic [NI*ELEMENT_WIDTH-1:0] p,
  input  logic                        in_valid,
  output logic                        in_ready,
  output logic [ELEMENT_WIDTH-1:0]    result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        busy
);

  localparam int SUM_W = 2 * ELEMENT_WIDTH + $clog2(NI);

  rbv_state_t                   state;
  logic [CNT_WIDTH-1:0]         count_q;
  logic [CNT_WIDTH-1:0]         accepted_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic                         take;
  logic                         s1_valid;
  logic signed [SUM_W-1:0]      sum;
  logic                         sum_valid;
  logic [ELEMENT_WIDTH-1:0]     result_d;

  // in_ready depends only on state and progress, never on in_valid.
  assign in_ready     = (state == RUN) && (accepted_q < count_q);
  assign take         = in_valid && in_ready;
  assign result_valid = (state == DONE);
  assign busy         = (state != IDLE);
  assign result_d     = ELEMENT_WIDTH'(rbv_narrow(NARROW_W'(acc_q), FRAC_BITS, ELEMENT_WIDTH));

  rbv_lane_tree #(
    .NI            (NI),
    .ELEMENT_WIDTH (ELEMENT_WIDTH)
  ) u_lane_tree (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (take),
    .a         (a),
    .p         (p),
    .s1_valid  (s1_valid),
    .sum       (sum),
    .sum_valid (sum_valid)
  );

  // S3: a fresh row clears the accumulator; valid S2 sums are added in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
    end else if (state == IDLE && start) begin
      acc_q <= '0;
    end else if (sum_valid) begin
      acc_q <= acc_q + ACC_WIDTH'(sum);
    end
  end

  // Controller: DRAIN waits for both tree stages to empty, at which point the
  // last sum has already landed in the accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      count_q    <= '0;
      accepted_q <= '0;
      result     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            count_q    <= no_of_multiples;
            accepted_q <= '0;
            if (no_of_multiples == '0) begin
              result <= '0;
              state  <= DONE;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (take) begin
            accepted_q <= accepted_q + CNT_WIDTH'(1);
            if (accepted_q + CNT_WIDTH'(1) == count_q) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (!s1_valid && !sum_valid) begin
            result <= result_d;
            state  <= DONE;
          end
        end
        DONE: begin
          if (result_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_row_by_vector_engine.sv
// tb_row_by_vector_engine
// Self-checking bench for row_by_vector_engine at default parameters.
// Expected results come from a plain-arithmetic dot-product model over the
// chunks queued for each row.
module tb_row_by_vector_engine;

  localparam int NI   = 8;
  localparam int EW   = 32;
  localparam int FRAC = 16;
  localparam int ACCW = 2 * EW + 16;
  localparam int CNTW = 32;

  logic            clk;
  logic            reset;
  logic            start;
  logic [CNTW-1:0] no_of_multiples;
  logic [NI*EW-1:0] a;
  logic [NI*EW-1:0] p;
  logic            in_valid;
  logic            in_ready;
  logic [EW-1:0]   result;
  logic            result_valid;
  logic            result_ready;
  logic            busy;

  int checks   = 0;
  int failures = 0;

  logic [NI*EW-1:0] row_a [$];
  logic [NI*EW-1:0] row_p [$];

  row_by_vector_engine #(
    .NI            (NI),
    .ELEMENT_WIDTH (EW),
    .FRAC_BITS     (FRAC),
    .ACC_WIDTH     (ACCW),
    .CNT_WIDTH     (CNTW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .no_of_multiples (no_of_multiples),
    .a               (a),
    .p               (p),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .result          (result),
    .result_valid    (result_valid),
    .result_ready    (result_ready),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NI*EW-1:0] splat(input logic [EW-1:0] v);
    logic [NI*EW-1:0] r;
    for (int k = 0; k < NI; k++) r[k*EW +: EW] = v;
    return r;
  endfunction

  function automatic logic [NI*EW-1:0] rand_chunk();
    logic [NI*EW-1:0] r;
    for (int k = 0; k < NI; k++) r[k*EW +: EW] = $urandom;
    return r;
  endfunction

  // Reference: exact signed dot product over all queued chunks, arithmetic
  // shift by the fractional bits, then saturate or wrap to the element width.
  function automatic logic [EW-1:0] model_dot();
    logic signed [127:0] total;
    logic signed [127:0] ea;
    logic signed [127:0] ep;
    logic signed [127:0] shifted;
    logic [NI*EW-1:0]    ca;
    logic [NI*EW-1:0]    cp;
    total = '0;
    for (int c = 0; c < row_a.size(); c++) begin
      ca = row_a[c];
      cp = row_p[c];
      for (int k = 0; k < NI; k++) begin
        ea = 128'($signed(ca[k*EW +: EW]));
        ep = 128'($signed(cp[k*EW +: EW]));
        total = total + ea * ep;
      end
    end
    shifted = total >>> FRAC;
`ifdef ROW_BY_VECTOR_SATURATE_EN
    if (shifted > 128'sd2147483647) return 32'h7FFF_FFFF;
    if (shifted < -128'sd2147483648) return 32'h8000_0000;
`endif
    return shifted[EW-1:0];
  endfunction

  // Issues start, streams the queued chunks with random gaps, then waits for
  // result_valid. latency counts rising edges after the last chunk handshake.
  task automatic drive_row(input int count, input int gap_pct,
                           output bit timed_out, output int latency);
    int idx;
    int budget;
    bit hs;
    timed_out       = 1'b0;
    start           = 1'b1;
    no_of_multiples = CNTW'(count);
    tick();
    start  = 1'b0;
    idx    = 0;
    budget = 400;
    while (idx < count && budget > 0) begin
      if (int'($urandom_range(99)) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        a        = row_a[idx];
        p        = row_p[idx];
      end
      hs = in_valid && in_ready;
      tick();
      if (hs) idx++;
      budget--;
    end
    in_valid = 1'b0;
    if (idx < count) timed_out = 1'b1;
    latency = 0;
    while (!result_valid && latency < 50) begin
      tick();
      latency++;
    end
    if (!result_valid) timed_out = 1'b1;
  endtask

  task automatic test_reset();
    reset           = 1'b1;
    start           = 1'b0;
    no_of_multiples = '0;
    a               = '0;
    p               = '0;
    in_valid        = 1'b0;
    result_ready    = 1'b1;
    tick();
    tick();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_result_valid: got %b expected 0", result_valid); end
    checks++; if (result !== '0) begin failures++; $display("[TB] FAIL reset_result: got %h expected 0", result); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_three_equal_chunks();
    bit to;
    int lat;
    logic [EW-1:0] exp_r;
    row_a.delete(); row_p.delete();
    for (int c = 0; c < 3; c++) begin
      row_a.push_back(splat(32'h0001_0000));
      row_p.push_back(splat(32'h0002_0000));
    end
    exp_r = model_dot();
    result_ready = 1'b1;
    drive_row(3, 0, to, lat);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL three_timeout: got %b expected 0", to); end
    // Valid rises on the third edge after the last handshake edge.
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL three_latency: got %0d expected 3", lat); end
    checks++; if (result !== 32'h0030_0000) begin failures++; $display("[TB] FAIL three_result_const: got %h expected 00300000", result); end
    checks++; if (result !== exp_r) begin failures++; $display("[TB] FAIL three_result_model: got %h expected %h", result, exp_r); end
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL three_idle_after: got busy=%b expected 0", busy); end
  endtask

  task automatic test_count_zero();
    result_ready    = 1'b1;
    start           = 1'b1;
    no_of_multiples = '0;
    tick();
    start = 1'b0;
    checks++; if (result_valid !== 1'b1) begin failures++; $display("[TB] FAIL zero_valid: got %b expected 1", result_valid); end
    checks++; if (result !== '0) begin failures++; $display("[TB] FAIL zero_result: got %h expected 0", result); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL zero_in_ready: got %b expected 0", in_ready); end
    checks++; if (busy !== 1'b1) begin failures++; $display("[TB] FAIL zero_busy: got %b expected 1", busy); end
    tick();
    checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL zero_done_one_cycle: got %b expected 0", result_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL zero_in_ready_after: got %b expected 0", in_ready); end
  endtask

  task automatic test_bubbles_backpressure();
    bit to;
    int lat;
    logic [EW-1:0] exp_r;
    logic [EW-1:0] held;
    row_a.delete(); row_p.delete();
    for (int c = 0; c < 2; c++) begin
      row_a.push_back(rand_chunk());
      row_p.push_back(rand_chunk());
    end
    exp_r = model_dot();
    result_ready = 1'b0;
    drive_row(2, 40, to, lat);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL bp_timeout: got %b expected 0", to); end
    checks++; if (result !== exp_r) begin failures++; $display("[TB] FAIL bp_result: got %h expected %h", result, exp_r); end
    held = exp_r;
    for (int i = 0; i < 10; i++) begin
      start           = 1'b1;
      no_of_multiples = CNTW'(1);
      checks++; if (result !== held) begin failures++; $display("[TB] FAIL bp_hold_result: cycle %0d got %h expected %h", i, result, held); end
      checks++; if (result_valid !== 1'b1) begin failures++; $display("[TB] FAIL bp_hold_valid: cycle %0d got %b expected 1", i, result_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL bp_hold_in_ready: cycle %0d got %b expected 0", i, in_ready); end
      tick();
    end
    start        = 1'b0;
    result_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL bp_start_ignored: got busy=%b expected 0", busy); end
    drive_row(2, 0, to, lat);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL bp_nogap_timeout: got %b expected 0", to); end
    checks++; if (result !== held) begin failures++; $display("[TB] FAIL bp_nogap_same: got %h expected %h", result, held); end
    tick();
  endtask

  task automatic test_saturation();
    bit to;
    int lat;
    logic [EW-1:0] exp_const;
    logic [EW-1:0] exp_r;
    row_a.delete(); row_p.delete();
    row_a.push_back(splat(32'h7FFF_0000));
    row_p.push_back(splat(32'h7FFF_0000));
    exp_r = model_dot();
`ifdef ROW_BY_VECTOR_SATURATE_EN
    exp_const = 32'h7FFF_FFFF;
`else
    // 8 * 0x3FFF000100000000 >>> 16 = 0x1FFF800080000; low 32 bits kept.
    exp_const = 32'h0008_0000;
`endif
    result_ready = 1'b1;
    drive_row(1, 0, to, lat);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL sat_timeout: got %b expected 0", to); end
    checks++; if (result !== exp_const) begin failures++; $display("[TB] FAIL sat_result_const: got %h expected %h", result, exp_const); end
    checks++; if (result !== exp_r) begin failures++; $display("[TB] FAIL sat_result_model: got %h expected %h", result, exp_r); end
    tick();
  endtask

  task automatic test_reset_mid_row();
    bit to;
    int lat;
    logic [EW-1:0] exp_r;
    result_ready    = 1'b1;
    start           = 1'b1;
    no_of_multiples = CNTW'(3);
    tick();
    start = 1'b0;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL mid_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1;
    a        = rand_chunk();
    p        = rand_chunk();
    tick();
    in_valid = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (result_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_valid: got %b expected 0", result_valid); end
    checks++; if (result !== '0) begin failures++; $display("[TB] FAIL mid_reset_result: got %h expected 0", result); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL mid_reset_busy: got %b expected 0", busy); end
    tick();
    reset = 1'b0;
    tick();
    row_a.delete(); row_p.delete();
    row_a.push_back(rand_chunk());
    row_p.push_back(rand_chunk());
    exp_r = model_dot();
    drive_row(1, 0, to, lat);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL mid_new_timeout: got %b expected 0", to); end
    checks++; if (result !== exp_r) begin failures++; $display("[TB] FAIL mid_new_result: got %h expected %h", result, exp_r); end
    tick();
  endtask

  task automatic test_back_to_back();
    bit to;
    int lat;
    logic [EW-1:0] exp1;
    logic [EW-1:0] exp2;
    result_ready = 1'b1;
    row_a.delete(); row_p.delete();
    for (int c = 0; c < 2; c++) begin
      row_a.push_back(rand_chunk());
      row_p.push_back(rand_chunk());
    end
    exp1 = model_dot();
    drive_row(2, 0, to, lat);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first_timeout: got %b expected 0", to); end
    checks++; if (result !== exp1) begin failures++; $display("[TB] FAIL b2b_first_result: got %h expected %h", result, exp1); end
    // Handshake edge; the next start is then accepted on the following edge.
    tick();
    row_a.delete(); row_p.delete();
    for (int c = 0; c < 3; c++) begin
      row_a.push_back(rand_chunk());
      row_p.push_back(rand_chunk());
    end
    exp2 = model_dot();
    drive_row(3, 0, to, lat);
    checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL b2b_second_timeout: got %b expected 0", to); end
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL b2b_second_latency: got %0d expected 3", lat); end
    checks++; if (result !== exp2) begin failures++; $display("[TB] FAIL b2b_second_result: got %h expected %h", result, exp2); end
    tick();
  endtask

  task automatic test_random_rows();
    bit to;
    int lat;
    int cnt;
    logic [EW-1:0] exp_r;
    result_ready = 1'b1;
    for (int r = 0; r < 6; r++) begin
      cnt = int'($urandom_range(4, 1));
      row_a.delete(); row_p.delete();
      for (int c = 0; c < cnt; c++) begin
        row_a.push_back(rand_chunk());
        row_p.push_back(rand_chunk());
      end
      exp_r = model_dot();
      drive_row(cnt, 30, to, lat);
      checks++; if (to !== 1'b0) begin failures++; $display("[TB] FAIL rand_timeout: row %0d got %b expected 0", r, to); end
      checks++; if (result !== exp_r) begin failures++; $display("[TB] FAIL rand_result: row %0d got %h expected %h", r, result, exp_r); end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_three_equal_chunks();
    test_count_zero();
    test_bubbles_backpressure();
    test_saturation();
    test_reset_mid_row();
    test_back_to_back();
    test_random_rows();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
